// File: rtl/lcd_ctrl.sv
// lcd_ctrl: write-only HD44780 bus sequencer behind the LSU store window.
// Runs the power-up init sequence, then paces software writes via busy.
module lcd_ctrl #(
    parameter int unsigned POWERUP_CYC = 750000,
    parameter int unsigned SETUP_CYC   = 4,
    parameter int unsigned EN_CYC      = 24,
    parameter int unsigned HOLD_CYC    = 4,
    parameter int unsigned EXEC_CYC    = 2500,
    parameter int unsigned CLEAR_CYC   = 82500
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_valid,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_status,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_overrun
);

    function automatic int unsigned max2(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_A   = max2(POWERUP_CYC, SETUP_CYC);
    localparam int unsigned MAX_B   = max2(EN_CYC, HOLD_CYC);
    localparam int unsigned MAX_C   = max2(EXEC_CYC, CLEAR_CYC);
    localparam int unsigned MAX_CYC = max2(max2(MAX_A, MAX_B), MAX_C);
    localparam int unsigned CNT_W   =
        (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t PWR_LAST = cnt_t'(POWERUP_CYC - 1);
    localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t EN_LD    = cnt_t'(EN_CYC - 1);
    localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYC - 1);
    localparam cnt_t EXEC_LD  = cnt_t'(EXEC_CYC - 1);
    localparam cnt_t CLEAR_LD = cnt_t'(CLEAR_CYC - 1);

    typedef enum logic [2:0] {
        S_INIT_WAIT,
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_EXEC
    } state_t;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] c;
        unique case (idx)
            2'd0:    c = 8'h38;
            2'd1:    c = 8'h0C;
            2'd2:    c = 8'h01;
            default: c = 8'h06;
        endcase
        return c;
    endfunction

    state_t     state, state_d;
    cnt_t       cnt, cnt_d;
    logic [8:0] cmd, cmd_d;
    logic [1:0] init_idx, init_idx_d;
    logic       init_done, init_done_d;
    logic       lcd_on, lcd_on_d;
    logic       sticky, sticky_d;
    logic       overrun, overrun_d;

    logic       busy;
    logic       cnt_zero;
    logic       is_clear;
    logic       wr_drop;
    logic       unused_wr_bits;

    assign busy     = (state != S_IDLE);
    assign cnt_zero = (cnt == '0);
    assign wr_drop  = i_wr_valid && busy;

    // Clear and home need the long execution wait; data never does.
    assign is_clear = !cmd[8] &&
                      ((cmd[7:0] == 8'h01) ||
                       (cmd[7:0] == 8'h02) ||
                       (cmd[7:0] == 8'h03));

    assign unused_wr_bits = ^i_wr_data[30:9];

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        cmd_d       = cmd;
        init_idx_d  = init_idx;
        init_done_d = init_done;
        lcd_on_d    = lcd_on;
        sticky_d    = sticky;
        overrun_d   = 1'b0;

        unique case (state)
            S_INIT_WAIT: begin
                if (cnt == PWR_LAST) begin
                    state_d    = S_SETUP;
                    cnt_d      = SETUP_LD;
                    init_idx_d = 2'd0;
                    cmd_d      = {1'b0, init_cmd(2'd0)};
                end else begin
                    cnt_d = cnt + cnt_t'(1);
                end
            end
            S_IDLE: begin
                if (i_wr_valid) begin
                    state_d  = S_SETUP;
                    cnt_d    = SETUP_LD;
                    cmd_d    = i_wr_data[8:0];
                    lcd_on_d = i_wr_data[31];
                    sticky_d = 1'b0;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_EN_HI;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt - cnt_t'(1);
                end
            end
            S_EN_HI: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt - cnt_t'(1);
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_EXEC;
                    cnt_d   = is_clear ? CLEAR_LD : EXEC_LD;
                end else begin
                    cnt_d = cnt - cnt_t'(1);
                end
            end
            S_EXEC: begin
                if (!cnt_zero) begin
                    cnt_d = cnt - cnt_t'(1);
                end else if (!init_done && init_idx != 2'd3) begin
                    state_d    = S_SETUP;
                    cnt_d      = SETUP_LD;
                    init_idx_d = init_idx + 2'd1;
                    cmd_d      = {1'b0, init_cmd(init_idx + 2'd1)};
                end else begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_INIT_WAIT;
                cnt_d   = '0;
            end
        endcase

        if (wr_drop) begin
            overrun_d = 1'b1;
            sticky_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= S_INIT_WAIT;
            cnt       <= '0;
            cmd       <= '0;
            init_idx  <= 2'd0;
            init_done <= 1'b0;
            lcd_on    <= 1'b0;
            sticky    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            cmd       <= cmd_d;
            init_idx  <= init_idx_d;
            init_done <= init_done_d;
            lcd_on    <= lcd_on_d;
            sticky    <= sticky_d;
            overrun   <= overrun_d;
        end
    end

    assign o_status   = {29'd0, init_done, sticky, busy};
    assign o_lcd_data = cmd[7:0];
    assign o_lcd_rs   = cmd[8];
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = (state == S_EN_HI);
    assign o_lcd_on   = lcd_on;
    assign o_overrun  = overrun;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: random and directed stores against a schedule-based model.
// The model predicts pin timing from command start times and lengths.
module tb_lcd_ctrl;

    localparam int PWR = 20;
    localparam int SU  = 2;
    localparam int EN  = 3;
    localparam int HD  = 2;
    localparam int EX  = 10;
    localparam int CLR = 40;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_wr_valid = 1'b0;
    logic [31:0] i_wr_data = '0;
    logic [31:0] o_status;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs;
    logic        o_lcd_rw;
    logic        o_lcd_en;
    logic        o_lcd_on;
    logic        o_overrun;

    lcd_ctrl #(
        .POWERUP_CYC(PWR),
        .SETUP_CYC  (SU),
        .EN_CYC     (EN),
        .HOLD_CYC   (HD),
        .EXEC_CYC   (EX),
        .CLEAR_CYC  (CLR)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_valid(i_wr_valid),
        .i_wr_data (i_wr_data),
        .o_status  (o_status),
        .o_lcd_data(o_lcd_data),
        .o_lcd_rs  (o_lcd_rs),
        .o_lcd_rw  (o_lcd_rw),
        .o_lcd_en  (o_lcd_en),
        .o_lcd_on  (o_lcd_on),
        .o_overrun (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    // model state
    int         busy_until;
    int         init_end;
    int         cur_start;
    logic [8:0] cur_cmd;
    logic       on_m, sticky_m, ovr_m;
    int         q_start[$];
    logic [8:0] q_cmd[$];
    logic       acc_f, drop_f;
    logic [31:0] acc_d;

    // observations
    logic       prev_en;
    int         en_rises[$];
    logic [8:0] en_data[$];
    int         busy_run;
    int         busy_runs[$];
    int         done_cyc;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, n, got, exp);
    endtask

    function automatic int cmd_len(input logic [8:0] c);
        bit clr;
        clr = !c[8] && c[7:0] >= 8'd1 && c[7:0] <= 8'd3;
        return SU + EN + HD + (clr ? CLR : EX);
    endfunction

    task automatic model_reset();
        int s;
        n = 0;
        q_start.delete();
        q_cmd.delete();
        s = PWR;
        for (int i = 0; i < 4; i++) begin
            q_start.push_back(s);
            q_cmd.push_back({1'b0, init_seq[i]});
            s += cmd_len({1'b0, init_seq[i]});
        end
        init_end   = s;
        busy_until = s;
        cur_start  = -1000000;
        cur_cmd    = '0;
        on_m = 0; sticky_m = 0; ovr_m = 0;
        acc_f = 0; drop_f = 0;
        prev_en = 0;
        en_rises.delete();
        en_data.delete();
        busy_run = 0;
        busy_runs.delete();
        done_cyc = -1;
    endtask

    task automatic check_cycle();
        int ph;
        logic busy_e, done_e, en_e;
        ph     = n - cur_start;
        busy_e = n < busy_until;
        done_e = n >= init_end;
        en_e   = ph >= SU && ph < SU + EN;
        check("status", o_status, {29'd0, done_e, sticky_m, busy_e});
        check("data", {24'd0, o_lcd_data}, {24'd0, cur_cmd[7:0]});
        check("rs", {31'd0, o_lcd_rs}, {31'd0, cur_cmd[8]});
        check("rw", {31'd0, o_lcd_rw}, 32'd0);
        check("en", {31'd0, o_lcd_en}, {31'd0, en_e});
        check("on", {31'd0, o_lcd_on}, {31'd0, on_m});
        check("ovr", {31'd0, o_overrun}, {31'd0, ovr_m});
        if (o_lcd_en && !prev_en) begin
            en_rises.push_back(n);
            en_data.push_back({o_lcd_rs, o_lcd_data});
        end
        prev_en = o_lcd_en;
        if (o_status[0]) busy_run++;
        else if (busy_run > 0) begin
            busy_runs.push_back(busy_run);
            busy_run = 0;
        end
        if (o_status[2] && done_cyc < 0) done_cyc = n;
    endtask

    task automatic advance();
        n++;
        ovr_m = drop_f;
        if (drop_f) sticky_m = 1'b1;
        if (acc_f) begin
            on_m       = acc_d[31];
            sticky_m   = 1'b0;
            cur_cmd    = acc_d[8:0];
            cur_start  = n;
            busy_until = n + cmd_len(acc_d[8:0]);
        end
        acc_f = 0;
        drop_f = 0;
        while (q_start.size() > 0 && q_start[0] <= n) begin
            cur_start = q_start.pop_front();
            cur_cmd   = q_cmd.pop_front();
        end
    endtask

    task automatic step(input logic v, input logic [31:0] d);
        i_wr_valid = v;
        i_wr_data  = d;
        @(negedge i_clk);
        check_cycle();
        if (v) begin
            if (n < busy_until) drop_f = 1'b1;
            else begin
                acc_f = 1'b1;
                acc_d = d;
            end
        end
        @(posedge i_clk);
        advance();
        #1;
        i_wr_valid = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 32'd0);
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        #1;
        check("rst_status", o_status, 32'h1);
        check("rst_en", {31'd0, o_lcd_en}, 32'd0);
        check("rst_on", {31'd0, o_lcd_on}, 32'd0);
        check("rst_data", {23'd0, o_lcd_rs, o_lcd_data}, 32'd0);
        check("rst_ovr", {31'd0, o_overrun}, 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        model_reset();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!o_status[0]) break;
            step(1'b0, 32'd0);
        end
        check("idle_to", {31'd0, o_status[0]}, 32'd0);
    endtask

    task automatic check_init(input string tag);
        check({tag, "_nrise"}, en_rises.size(), 4);
        if (en_rises.size() >= 4) begin
            check({tag, "_rise0"}, en_rises[0], 22);
            for (int i = 0; i < 4; i++)
                check({tag, "_cmd"}, {23'd0, en_data[i]},
                      {24'd0, init_seq[i]});
        end
        check({tag, "_done"}, done_cyc, 118);
    endtask

    initial begin
        int wr_cyc;
        logic v;
        logic [31:0] d;
        logic [7:0] b;

        #2;
        do_reset();

        // power-up init with no stimulus
        idle(120);
        check_init("init");
        check("init_stat", o_status, 32'h4);

        // data write with power on
        wr_cyc = n;
        step(1'b1, 32'h8000_0141);
        check("wr_busy", {31'd0, o_status[0]}, 32'd1);
        check("wr_on", {31'd0, o_lcd_on}, 32'd1);
        check("wr_data", {23'd0, o_lcd_rs, o_lcd_data}, 32'h141);
        idle(22);
        check("wr_en_at", en_rises[$] - (wr_cyc + 1), 2);
        check("wr_busy_len", busy_runs[$], 17);

        // clear command, power off
        step(1'b1, 32'h0000_0001);
        idle(50);
        check("clr_busy_len", busy_runs[$], 47);
        check("clr_on", {31'd0, o_lcd_on}, 32'd0);

        // overrun while busy
        step(1'b1, 32'h0000_0155);
        idle(4);
        step(1'b1, 32'h8000_0142);
        check("ovr_pulse", {31'd0, o_overrun}, 32'd1);
        check("ovr_stat", o_status, 32'h7);
        check("ovr_pins", {23'd0, o_lcd_rs, o_lcd_data}, 32'h155);
        step(1'b0, 32'd0);
        check("ovr_1cyc", {31'd0, o_overrun}, 32'd0);
        wait_idle();
        check("ovr_sticky", {31'd0, o_status[1]}, 32'd1);
        step(1'b1, 32'h0000_0148);
        check("ovr_clr", {31'd0, o_status[1]}, 32'd0);
        wait_idle();

        // write during init
        do_reset();
        idle(30);
        step(1'b1, 32'h8000_0155);
        check("init_drop", {31'd0, o_overrun}, 32'd1);
        check("init_drop_on", {31'd0, o_lcd_on}, 32'd0);
        idle(90);
        check_init("init2");
        check("init2_stat", o_status, 32'h6);

        // reset during EN high of a data write
        step(1'b1, 32'h8000_0150);
        for (int i = 0; i < 10; i++) begin
            if (o_lcd_en) break;
            step(1'b0, 32'd0);
        end
        check("en_seen", {31'd0, o_lcd_en}, 32'd1);
        do_reset();
        idle(30);
        check("rst_rise", en_rises.size() > 0 ? en_rises[0] : -1, 22);
        idle(95);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 3) == 0);
            d = $urandom;
            b = $urandom_range(0, 1) ? 8'($urandom)
                                     : 8'($urandom_range(1, 3));
            d[7:0] = b;
            step(v, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
